// File: rtl/db_load_responder.sv
// rtl/db_load_responder.sv - database block load responder with one-entry block cache
//
// Serves block loads from the seed-expansion FSM. A load request carries a
// bit-address; the 512-bit block holding it is returned on db_data with a
// one-cycle data_valid, either from the one-entry cache or from memory.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   load, address            request level and bit-address (sampled in IDLE)
//   load_done                one-cycle acknowledge of an accepted request
//   data_valid, db_data      one-cycle data strobe and returned block
//   addr_err                 sticky out-of-range flag
//   mem_rd_en/addr/ready     memory read request handshake
//   mem_rd_valid/data        memory read data return
//   hit_count                saturating cache-hit counter
module db_load_responder #(
  parameter int          MEM_AW    = 23,
  parameter int unsigned DB_BLOCKS = 131072
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [31:0]       address,
  output logic              load_done,
  output logic              data_valid,
  output logic [511:0]      db_data,
  output logic              addr_err,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_ready,
  input  logic              mem_rd_valid,
  input  logic [511:0]      mem_rd_data,
  output logic [15:0]       hit_count
);

  localparam logic [31:0] DB_LIMIT = 32'(DB_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_MEMREQ,
    S_MEMWAIT,
    S_DELIVER
  } state_t;

  state_t              state_q;
  logic [22:0]         idx_q;
  logic [22:0]         tag_q;
  logic                cache_vld_q;
  logic [511:0]        cache_q;
  logic                route_err_q;
  logic                route_hit_q;
  logic                load_done_q;
  logic                data_valid_q;
  logic [511:0]        db_data_q;
  logic                addr_err_q;
  logic                mem_rd_en_q;
  logic [MEM_AW-1:0]   mem_rd_addr_q;
  logic [15:0]         hit_count_q;

  // Request decode, evaluated on the incoming address while IDLE.
  logic [22:0] req_idx_d;
  logic        req_oor_d;
  logic        req_hit_d;
  logic        unused_addr_bits;

  assign req_idx_d        = address[31:9];
  assign req_oor_d        = ({9'd0, req_idx_d} >= DB_LIMIT);
  assign req_hit_d        = cache_vld_q && (tag_q == req_idx_d);
  assign unused_addr_bits = ^address[8:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      tag_q         <= '0;
      cache_vld_q   <= 1'b0;
      cache_q       <= '0;
      route_err_q   <= 1'b0;
      route_hit_q   <= 1'b0;
      load_done_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      db_data_q     <= '0;
      addr_err_q    <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      hit_count_q   <= '0;
    end else begin
      load_done_q  <= 1'b0;
      data_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (load) begin
            idx_q       <= req_idx_d;
            load_done_q <= 1'b1;
            // The route is decided now; ACK only spends the load_done cycle
            // so data_valid can never coincide with load_done.
            route_err_q <= req_oor_d;
            route_hit_q <= !req_oor_d && req_hit_d;
            if (req_oor_d) begin
              addr_err_q <= 1'b1;
            end else if (req_hit_d && (hit_count_q != 16'hFFFF)) begin
              hit_count_q <= hit_count_q + 16'd1;
            end
            state_q <= S_ACK;
          end
        end

        S_ACK: begin
          if (route_err_q) begin
            db_data_q    <= '0;
            data_valid_q <= 1'b1;
            state_q      <= S_DELIVER;
          end else if (route_hit_q) begin
            db_data_q    <= cache_q;
            data_valid_q <= 1'b1;
            state_q      <= S_DELIVER;
          end else begin
            mem_rd_en_q   <= 1'b1;
            mem_rd_addr_q <= idx_q[MEM_AW-1:0];
            state_q       <= S_MEMREQ;
          end
        end

        S_MEMREQ: begin
          if (mem_rd_ready) begin
            mem_rd_en_q <= 1'b0;
            // Zero-latency memory returns data on the handshake cycle itself.
            if (mem_rd_valid) begin
              db_data_q    <= mem_rd_data;
              cache_q      <= mem_rd_data;
              tag_q        <= idx_q;
              cache_vld_q  <= 1'b1;
              data_valid_q <= 1'b1;
              state_q      <= S_DELIVER;
            end else begin
              state_q <= S_MEMWAIT;
            end
          end
        end

        S_MEMWAIT: begin
          if (mem_rd_valid) begin
            db_data_q    <= mem_rd_data;
            cache_q      <= mem_rd_data;
            tag_q        <= idx_q;
            cache_vld_q  <= 1'b1;
            data_valid_q <= 1'b1;
            state_q      <= S_DELIVER;
          end
        end

        S_DELIVER: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign load_done   = load_done_q;
  assign data_valid  = data_valid_q;
  assign db_data     = db_data_q;
  assign addr_err    = addr_err_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_db_load_responder.sv
// tb/tb_db_load_responder.sv - self-checking bench for db_load_responder
module tb_db_load_responder;

  localparam int          MEM_AW    = 23;
  localparam int unsigned DB_BLOCKS = 131072;

  logic              clk;
  logic              rst;
  logic              load;
  logic [31:0]       address;
  logic              load_done;
  logic              data_valid;
  logic [511:0]      db_data;
  logic              addr_err;
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_rd_addr;
  logic              mem_rd_ready;
  logic              mem_rd_valid;
  logic [511:0]      mem_rd_data;
  logic [15:0]       hit_count;

  int    n_tests;
  int    n_fail;
  string cur;

  db_load_responder #(.MEM_AW(MEM_AW), .DB_BLOCKS(DB_BLOCKS)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .address      (address),
    .load_done    (load_done),
    .data_valid   (data_valid),
    .db_data      (db_data),
    .addr_err     (addr_err),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .hit_count    (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Deterministic content of each memory block.
  function automatic logic [511:0] blk_data(input logic [22:0] i);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) begin
      d[32*k +: 32] = 32'hA5A5_A5A5 ^ ({9'd0, i} * 32'h0100_0193) ^ (32'(k) * 32'h1111_1111);
    end
    return d;
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, want %0d", cur, name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, want %0h", cur, name, act, exp);
    end
  endtask

  // One request/response transaction with a cooperating memory model.
  // Cycle 0 is the first cycle load is high; the requester keeps load high
  // through the load_done cycle plus 'hold' extra cycles.
  task automatic run_txn(input logic [31:0] addr, input int rdy, input int lat, input int hold,
                         input int exp_dv_t, input int exp_en, input logic [22:0] exp_idx,
                         input logic [511:0] exp_data, input logic exp_err, input int exp_hc);
    int t, ld_cnt, ld_t, dv_cnt, dv_t, en_cnt, hs_t, bad_addr;
    logic [511:0]      dv_data;
    logic [MEM_AW-1:0] hs_addr;
    ld_cnt = 0; ld_t = -1; dv_cnt = 0; dv_t = -1; en_cnt = 0; hs_t = -1; bad_addr = 0;
    dv_data = '0; hs_addr = '0;
    load = 1'b1; address = addr; mem_rd_ready = 1'b0; mem_rd_valid = 1'b0;
    t = 0;
    while (t < 60 && !(dv_t >= 0 && t >= dv_t + 2)) begin
      @(negedge clk);
      t++;
      if (load_done) begin ld_cnt++; ld_t = t; end
      if (data_valid) begin dv_cnt++; dv_t = t; dv_data = db_data; end
      if (mem_rd_en) begin
        en_cnt++;
        if (mem_rd_addr != exp_idx[MEM_AW-1:0]) bad_addr++;
      end
      load         = (t <= 1 + hold);
      mem_rd_valid = 1'b0;
      mem_rd_ready = mem_rd_en && (en_cnt > rdy);
      if (mem_rd_ready && hs_t < 0) begin
        hs_t    = t;
        hs_addr = mem_rd_addr;
        if (lat == 0) mem_rd_valid = 1'b1;
      end
      if (hs_t >= 0 && lat > 0 && t == hs_t + lat) mem_rd_valid = 1'b1;
      mem_rd_data = mem_rd_valid ? blk_data(hs_addr) : {16{$urandom}};
    end
    load = 1'b0; mem_rd_ready = 1'b0; mem_rd_valid = 1'b0;
    chk_int("load_done_count", ld_cnt, 1);
    chk_int("load_done_cycle", ld_t, 1);
    chk_int("data_valid_count", dv_cnt, 1);
    chk_int("data_valid_cycle", dv_t, exp_dv_t);
    chk_vec("db_data", dv_data, exp_data);
    chk_vec("db_data_stable", db_data, exp_data);
    chk_int("mem_rd_en_cycles", en_cnt, exp_en);
    chk_int("mem_rd_addr_errors", bad_addr, 0);
    chk_int("addr_err", int'(addr_err), int'(exp_err));
    chk_int("hit_count", int'(hit_count), exp_hc);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          rdy;
    int          lat;
    int          hold;
    int          dv_t;
    int          en;
    logic [22:0] idx;
    bit          zero;
    bit          err;
    int          hc;
  } vec_t;

  vec_t vt[10];

  // Reference model state: which block the cache holds, sticky error, hits.
  bit          m_vld;
  logic [22:0] m_tag;
  bit          m_err;
  int          m_hc;

  initial begin
    int          dv_seen;
    logic [31:0] a;
    logic [22:0] idx;
    int          rdy, lat, hold, dvt, en, sel;
    logic [511:0] ed;

    n_tests = 0; n_fail = 0; cur = "init";

    //                addr          rdy lat hold dv  en idx        zero err hc
    vt[0] = '{32'd1100,           0, 3, 0,   6,  1, 23'd2,      0, 0, 0};
    vt[1] = '{32'd1300,           0, 0, 0,   2,  0, 23'd2,      0, 0, 1};
    vt[2] = '{32'd788,            4, 1, 0,   8,  5, 23'd1,      0, 0, 1};
    vt[3] = '{32'd1000,           0, 0, 1,   2,  0, 23'd1,      0, 0, 2};
    vt[4] = '{32'd67108864,       0, 0, 0,   2,  0, 23'd131072, 1, 1, 2};
    vt[5] = '{32'd1100,           0, 0, 0,   3,  1, 23'd2,      0, 1, 2};
    vt[6] = '{32'hFFFF_FFFF,      0, 0, 1,   2,  0, 23'h7FFFFF, 1, 1, 2};
    vt[7] = '{32'd67108357,       2, 2, 0,   7,  3, 23'd131071, 0, 1, 2};
    vt[8] = '{32'd67108752,       0, 0, 0,   2,  0, 23'd131071, 0, 1, 3};
    vt[9] = '{32'd0,              1, 1, 2,   5,  2, 23'd0,      0, 1, 3};

    // Reset with load and mem_rd_valid held high.
    rst = 1'b0; load = 1'b1; address = 32'd1100;
    mem_rd_ready = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = '1;
    repeat (3) @(negedge clk);
    cur = "reset";
    chk_int("load_done", int'(load_done), 0);
    chk_int("data_valid", int'(data_valid), 0);
    chk_vec("db_data", db_data, '0);
    chk_int("addr_err", int'(addr_err), 0);
    chk_int("mem_rd_en", int'(mem_rd_en), 0);
    chk_int("mem_rd_addr", int'(mem_rd_addr), 0);
    chk_int("hit_count", int'(hit_count), 0);
    rst = 1'b1;
    @(negedge clk);
    chk_int("first_load_done", int'(load_done), 1);
    // Abort mid-request and make sure nothing is delivered.
    rst = 1'b0; load = 1'b0; mem_rd_ready = 1'b0; mem_rd_valid = 1'b0;
    dv_seen = 0;
    repeat (2) begin @(negedge clk); if (data_valid) dv_seen++; end
    rst = 1'b1;
    repeat (3) begin @(negedge clk); if (data_valid) dv_seen++; end
    chk_int("abort_no_data_valid", dv_seen, 0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      cur = $sformatf("vec%0d", i);
      ed  = vt[i].zero ? 512'd0 : blk_data(vt[i].idx);
      run_txn(vt[i].addr, vt[i].rdy, vt[i].lat, vt[i].hold, vt[i].dv_t, vt[i].en,
              vt[i].idx, ed, vt[i].err, vt[i].hc);
    end

    // Reset during MEMWAIT: transaction aborted, cache (block 0) invalidated.
    cur = "memwait_reset";
    load = 1'b1; address = 32'd1100;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk_int("mem_rd_en", int'(mem_rd_en), 1);
    mem_rd_ready = 1'b1;
    @(negedge clk);
    mem_rd_ready = 1'b0;
    chk_int("mem_rd_en_dropped", int'(mem_rd_en), 0);
    rst = 1'b0;
    #1;
    chk_int("hit_count_cleared", int'(hit_count), 0);
    chk_int("addr_err_cleared", int'(addr_err), 0);
    @(negedge clk);
    rst = 1'b1; mem_rd_valid = 1'b1; mem_rd_data = blk_data(23'd2);
    dv_seen = 0;
    @(negedge clk);
    mem_rd_valid = 1'b0;
    repeat (4) begin if (data_valid) dv_seen++; @(negedge clk); end
    chk_int("no_data_valid", dv_seen, 0);
    cur = "post_reset_blk0";
    run_txn(32'd40, 0, 1, 0, 4, 1, 23'd0, blk_data(23'd0), 1'b0, 0);
    cur = "post_reset_blk2";
    run_txn(32'd1100, 0, 0, 0, 3, 1, 23'd2, blk_data(23'd2), 1'b0, 0);
    cur = "post_reset_blk2_hit";
    run_txn(32'd1300, 0, 0, 0, 2, 0, 23'd2, blk_data(23'd2), 1'b0, 1);

    // Randomized traffic against the reference model.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    m_vld = 1'b0; m_tag = '0; m_err = 1'b0; m_hc = 0;
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       idx = 23'($urandom_range(0, 5));
      else if (sel < 9)  idx = 23'(DB_BLOCKS - 2 + $urandom_range(0, 3));
      else               idx = 23'($urandom >> 9);
      a   = {idx, 9'($urandom)};
      rdy = int'($urandom_range(0, 3));
      lat = int'($urandom_range(0, 3));
      if ({9'd0, idx} >= DB_BLOCKS) begin
        dvt = 2; en = 0; ed = '0; m_err = 1'b1;
        hold = int'($urandom_range(0, 1));
      end else if (m_vld && m_tag == idx) begin
        dvt = 2; en = 0; ed = blk_data(idx);
        if (m_hc < 65535) m_hc++;
        hold = int'($urandom_range(0, 1));
      end else begin
        dvt = 3 + rdy + lat; en = rdy + 1; ed = blk_data(idx);
        m_vld = 1'b1; m_tag = idx;
        hold = int'($urandom_range(0, 2));
      end
      cur = $sformatf("rand%0d", n);
      run_txn(a, rdy, lat, hold, dvt, en, idx, ed, m_err, m_hc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
